dcache_mem_assoc: RTL and testbench
===================================

# dcache_mem_assoc

Parametrised set-associative data-cache storage array for the load/store path, between the dcache controller and the SRAM-style tag/data state. It serves several combinational lookup ports and several byte-masked store ports, plus one line-fill port. The fill port allocates a way using true-LRU replacement and reports any dirty victim for write-back one cycle later. Valid, dirty and LRU state live inside this block; the controller only issues requests and consumes evictions.

## Interface
Parameters:
- SETS, 16, number of sets (power of two, ≥2); IDX_W = $clog2(SETS)
- WAYS, 2, associativity (power of two, ≥2); AGE_W = $clog2(WAYS)
- RD_PORTS, 3, lookup ports
- ST_PORTS, 2, store ports
- TAG_W, 8, tag width

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- rd_en  in  [RD_PORTS]  lookup request
- rd_idx  in  [RD_PORTS][IDX_W]  lookup set
- rd_tag  in  [RD_PORTS][TAG_W]  lookup tag
- rd_hit  out  [RD_PORTS]  rd_en & a valid way matches the tag
- rd_data  out  [RD_PORTS][64]  hit line data; 0 when no hit
- st_en  in  [ST_PORTS]  store request
- st_idx, st_tag  in  [ST_PORTS][IDX_W], [ST_PORTS][TAG_W]  store line address
- st_be  in  [ST_PORTS][8]  byte enables
- st_data  in  [ST_PORTS][64]  store data, byte-lane aligned
- st_hit  out  [ST_PORTS]  store hits; the write is performed only if 1
- fill_en  in  1  install a line from memory
- fill_idx, fill_tag, fill_data  in  IDX_W, TAG_W, 64  fill line
- evict_valid  out  1  registered: dirty victim produced by the previous cycle's fill
- evict_idx, evict_tag, evict_data  out  IDX_W, TAG_W, 64  victim address and data

## Operation
- Lookup and hit outputs are combinational from the current registered state. There is no bypass of same-cycle stores or fills.
- Store hit: at the edge, bytes with st_be=1 are written into the hit way and its dirty bit is set. When several store ports hit the same way, writes merge per byte and the higher port index wins overlapping bytes.
- Fill when the tag is already resident in the set: dropped, no state change, no eviction.
- Fill otherwise selects a victim way:
  - the lowest-index invalid way, else
  - the way with age = WAYS-1 (the LRU way).
- On fill, the victim way gets valid=1, dirty=0, tag and data from the fill port.
- If the victim was valid and dirty, the next cycle drives evict_valid=1 with the victim's old idx, tag and data. evict_valid lasts one cycle, with no handshake; the controller must accept it.
- LRU per set uses one age per way, with 0 = MRU. Touching way w sets age[w]=0 and increments every age below the old age[w].
- Touches happen, in this order within one edge:
  - rd ports in ascending index (rd_en & hit only),
  - then st ports in ascending index (hits only),
  - then the fill way.
  The fill way is therefore MRU.
- A fill that replaces a way hit by a same-cycle store wins; that store is lost, and the controller must not issue it.

## Timing
- Lookup and store-hit latency: 0 cycles (combinational). Store data is visible on rd_data from the cycle after the edge.
- Fill data is visible in the cycle after the fill_en edge. evict_* are valid in that same cycle.
- Reset (any cycle, including mid-fill) does the following:
  - clears valid, dirty, tags and data;
  - sets age[w]=w in every set;
  - drives evict_valid=0 and evict_idx/tag/data=0 from the next cycle.
- Outputs during reset: rd_hit=0, st_hit=0, rd_data=0.
- Back-to-back fills to the same set are legal; each produces its own eviction, one cycle apart.

## Structure
- dcache_pkg holds:
  - DCACHE_LINE_BITS=64 and DCACHE_LINE_BYTES=8;
  - typedef dcache_line_t and dcache_be_t;
  - struct dcache_evict_t {valid, idx, tag, data}.
- Sub-module dcache_lru_set: one set's age vector, ordered touch inputs, invalid mask, next ages and victim index. It is instantiated per set.

## Test plan
(SETS=16, WAYS=2)
- Reset, then rd idx 3 tag 0x12 -> rd_hit=0, rd_data=0, evict_valid=0.
- Fill idx 3 tag 0x12 data 0x1111_1111_1111_1111, then rd next cycle -> rd_hit=1, data matches, evict_valid=0.
- Store idx 3 tag 0x12 be 0x0F data 0xAAAA_AAAA_BBBB_BBBB -> st_hit=1; next cycle rd_data=0x1111_1111_BBBB_BBBB.
- Dirty eviction sequence:
  - fill tag 0x34 (goes to way1), rd 0x34, fill tag 0x56;
  - next cycle: evict_valid=1, idx 3, tag 0x12, data 0x1111_1111_BBBB_BBBB;
  - cycle after: evict_valid=0.
- Same as previous but rd 0x12 before the 0x56 fill -> victim is 0x34 (clean), evict_valid stays 0; a fill of tag 0x12 is dropped with no change.
- Same-cycle stores, port0 be 0x03 data 0x..AA_AA, port1 be 0x01 data 0x..55 on one line -> byte0=0x55, byte1=0xAA; reset asserted the cycle after a dirty-victim fill -> evict_valid=0.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types for the set-associative data-cache storage array.
// Line and byte-enable types plus the registered eviction record.
package dcache_pkg;

    localparam int DCACHE_LINE_BITS  = 64;
    localparam int DCACHE_LINE_BYTES = 8;

    // Widest idx/tag any instance may use; narrower instances zero-extend.
    localparam int DCACHE_IDX_MAX_W = 16;
    localparam int DCACHE_TAG_MAX_W = 32;

    typedef logic [DCACHE_LINE_BITS-1:0]  dcache_line_t;
    typedef logic [DCACHE_LINE_BYTES-1:0] dcache_be_t;

    typedef struct packed {
        logic                        valid;
        logic [DCACHE_IDX_MAX_W-1:0] idx;
        logic [DCACHE_TAG_MAX_W-1:0] tag;
        dcache_line_t                data;
    } dcache_evict_t;

endpackage

// File: rtl/dcache_lru_set.sv
// True-LRU age vector for one set: applies ordered touches, picks victim.
// Age 0 is MRU; the victim is the lowest invalid way, else age WAYS-1.
module dcache_lru_set #(
    parameter int WAYS    = 2,
    parameter int AGE_W   = $clog2(WAYS),
    parameter int N_TOUCH = 5
) (
    input  logic [WAYS-1:0][AGE_W-1:0]    age_i,
    input  logic [N_TOUCH-1:0]            touch_en_i,
    input  logic [N_TOUCH-1:0][AGE_W-1:0] touch_way_i,
    input  logic [WAYS-1:0]               inval_i,
    input  logic                          fill_i,
    output logic [WAYS-1:0][AGE_W-1:0]    age_o,
    output logic [AGE_W-1:0]              victim_o
);

    function automatic logic [WAYS-1:0][AGE_W-1:0] touch(
        input logic [WAYS-1:0][AGE_W-1:0] a,
        input logic [AGE_W-1:0]           way
    );
        logic [WAYS-1:0][AGE_W-1:0] r;
        logic [AGE_W-1:0]           old;
        r   = a;
        old = a[way];
        for (int v = 0; v < WAYS; v++) begin
            if (a[v] < old) r[v] = a[v] + 1'b1;
        end
        r[way] = '0;
        return r;
    endfunction

    always_comb begin
        logic found;
        found    = 1'b0;
        victim_o = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && inval_i[w]) begin
                victim_o = AGE_W'(w);
                found    = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_i[w] == AGE_W'(WAYS - 1)) victim_o = AGE_W'(w);
            end
        end
    end

    always_comb begin
        age_o = age_i;
        for (int t = 0; t < N_TOUCH; t++) begin
            if (touch_en_i[t]) age_o = touch(age_o, touch_way_i[t]);
        end
        if (fill_i) age_o = touch(age_o, victim_o);
    end

endmodule

// File: rtl/dcache_mem_assoc.sv
// Set-associative dcache tag/data/state array with lookup, store and fill
// ports; fills replace by true LRU and report dirty victims a cycle later.
module dcache_mem_assoc
    import dcache_pkg::*;
#(
    parameter int SETS     = 16,
    parameter int WAYS     = 2,
    parameter int RD_PORTS = 3,
    parameter int ST_PORTS = 2,
    parameter int TAG_W    = 8,
    parameter int IDX_W    = $clog2(SETS),
    parameter int AGE_W    = $clog2(WAYS)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [RD_PORTS-1:0]                rd_en,
    input  logic [RD_PORTS-1:0][IDX_W-1:0]     rd_idx,
    input  logic [RD_PORTS-1:0][TAG_W-1:0]     rd_tag,
    output logic [RD_PORTS-1:0]                rd_hit,
    output logic [RD_PORTS-1:0][63:0]          rd_data,
    input  logic [ST_PORTS-1:0]                st_en,
    input  logic [ST_PORTS-1:0][IDX_W-1:0]     st_idx,
    input  logic [ST_PORTS-1:0][TAG_W-1:0]     st_tag,
    input  logic [ST_PORTS-1:0][7:0]           st_be,
    input  logic [ST_PORTS-1:0][63:0]          st_data,
    output logic [ST_PORTS-1:0]                st_hit,
    input  logic                               fill_en,
    input  logic [IDX_W-1:0]                   fill_idx,
    input  logic [TAG_W-1:0]                   fill_tag,
    input  logic [63:0]                        fill_data,
    output logic                               evict_valid,
    output logic [IDX_W-1:0]                   evict_idx,
    output logic [TAG_W-1:0]                   evict_tag,
    output logic [63:0]                        evict_data
);

    localparam int N_TOUCH = RD_PORTS + ST_PORTS;

    logic [SETS-1:0][WAYS-1:0]             valid_q, valid_d;
    logic [SETS-1:0][WAYS-1:0]             dirty_q, dirty_d;
    logic [SETS-1:0][WAYS-1:0][TAG_W-1:0]  tag_q, tag_d;
    logic [SETS-1:0][WAYS-1:0][63:0]       data_q, data_d;
    logic [SETS-1:0][WAYS-1:0][AGE_W-1:0]  age_q, age_d, age_rst;
    dcache_evict_t                         evict_q, evict_d;

    logic [RD_PORTS-1:0]             rd_match;
    logic [RD_PORTS-1:0][AGE_W-1:0]  rd_way;
    logic [ST_PORTS-1:0]             st_match;
    logic [ST_PORTS-1:0][AGE_W-1:0]  st_way;
    logic                            fill_match, fill_do;
    logic [AGE_W-1:0]                fill_way;
    logic [SETS-1:0][AGE_W-1:0]      victim;

    always_comb begin
        rd_match   = '0;
        rd_way     = '0;
        st_match   = '0;
        st_way     = '0;
        fill_match = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            for (int p = 0; p < RD_PORTS; p++) begin
                if (valid_q[rd_idx[p]][w] && tag_q[rd_idx[p]][w] == rd_tag[p]) begin
                    rd_match[p] = 1'b1;
                    rd_way[p]   = AGE_W'(w);
                end
            end
            for (int p = 0; p < ST_PORTS; p++) begin
                if (valid_q[st_idx[p]][w] && tag_q[st_idx[p]][w] == st_tag[p]) begin
                    st_match[p] = 1'b1;
                    st_way[p]   = AGE_W'(w);
                end
            end
            if (valid_q[fill_idx][w] && tag_q[fill_idx][w] == fill_tag) fill_match = 1'b1;
        end
        fill_way = victim[fill_idx];
        fill_do  = fill_en && !fill_match;
    end

    assign rd_hit = rd_en & rd_match & {RD_PORTS{~reset}};
    assign st_hit = st_en & st_match & {ST_PORTS{~reset}};

    always_comb begin
        for (int p = 0; p < RD_PORTS; p++) begin
            rd_data[p] = rd_hit[p] ? data_q[rd_idx[p]][rd_way[p]] : 64'h0;
        end
    end

    for (genvar s = 0; s < SETS; s++) begin : g_set
        logic [N_TOUCH-1:0]            t_en;
        logic [N_TOUCH-1:0][AGE_W-1:0] t_way;

        always_comb begin
            for (int p = 0; p < RD_PORTS; p++) begin
                t_en[p]  = rd_hit[p] && rd_idx[p] == IDX_W'(s);
                t_way[p] = rd_way[p];
            end
            for (int p = 0; p < ST_PORTS; p++) begin
                t_en[RD_PORTS+p]  = st_hit[p] && st_idx[p] == IDX_W'(s);
                t_way[RD_PORTS+p] = st_way[p];
            end
        end

        dcache_lru_set #(
            .WAYS    (WAYS),
            .AGE_W   (AGE_W),
            .N_TOUCH (N_TOUCH)
        ) u_lru (
            .age_i       (age_q[s]),
            .touch_en_i  (t_en),
            .touch_way_i (t_way),
            .inval_i     (~valid_q[s]),
            .fill_i      (fill_do && fill_idx == IDX_W'(s)),
            .age_o       (age_d[s]),
            .victim_o    (victim[s])
        );
    end

    // Stores apply in port order so the higher port wins shared bytes; fill last.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        for (int p = 0; p < ST_PORTS; p++) begin
            if (st_hit[p]) begin
                dirty_d[st_idx[p]][st_way[p]] = 1'b1;
                for (int b = 0; b < DCACHE_LINE_BYTES; b++) begin
                    if (st_be[p][b])
                        data_d[st_idx[p]][st_way[p]][b*8 +: 8] = st_data[p][b*8 +: 8];
                end
            end
        end
        if (fill_do) begin
            valid_d[fill_idx][fill_way] = 1'b1;
            dirty_d[fill_idx][fill_way] = 1'b0;
            tag_d[fill_idx][fill_way]   = fill_tag;
            data_d[fill_idx][fill_way]  = fill_data;
        end
    end

    always_comb begin
        evict_d = '0;
        if (fill_do && valid_q[fill_idx][fill_way] && dirty_q[fill_idx][fill_way]) begin
            evict_d.valid = 1'b1;
            evict_d.idx   = DCACHE_IDX_MAX_W'(fill_idx);
            evict_d.tag   = DCACHE_TAG_MAX_W'(tag_q[fill_idx][fill_way]);
            evict_d.data  = data_q[fill_idx][fill_way];
        end
    end

    always_comb begin
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) age_rst[s][w] = AGE_W'(w);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
            tag_q   <= '0;
            data_q  <= '0;
            age_q   <= age_rst;
            evict_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            age_q   <= age_d;
            evict_q <= evict_d;
        end
    end

    assign evict_valid = evict_q.valid;
    assign evict_idx   = evict_q.idx[IDX_W-1:0];
    assign evict_tag   = evict_q.tag[TAG_W-1:0];
    assign evict_data  = evict_q.data;

    logic unused_evict_bits;
    assign unused_evict_bits = ^{evict_q.idx, evict_q.tag};

endmodule

// File: tb/tb_dcache_mem_assoc.sv
// Self-checking bench for dcache_mem_assoc: vector table on set 3,
// plus multi-port store and back-to-back eviction sequences on set 5.
module tb_dcache_mem_assoc;

    logic              clock;
    logic              reset;
    logic [2:0]        rd_en;
    logic [2:0][3:0]   rd_idx;
    logic [2:0][7:0]   rd_tag;
    logic [2:0]        rd_hit;
    logic [2:0][63:0]  rd_data;
    logic [1:0]        st_en;
    logic [1:0][3:0]   st_idx;
    logic [1:0][7:0]   st_tag;
    logic [1:0][7:0]   st_be;
    logic [1:0][63:0]  st_data;
    logic [1:0]        st_hit;
    logic              fill_en;
    logic [3:0]        fill_idx;
    logic [7:0]        fill_tag;
    logic [63:0]       fill_data;
    logic              evict_valid;
    logic [3:0]        evict_idx;
    logic [7:0]        evict_tag;
    logic [63:0]       evict_data;

    dcache_mem_assoc dut (
        .clock       (clock),
        .reset       (reset),
        .rd_en       (rd_en),
        .rd_idx      (rd_idx),
        .rd_tag      (rd_tag),
        .rd_hit      (rd_hit),
        .rd_data     (rd_data),
        .st_en       (st_en),
        .st_idx      (st_idx),
        .st_tag      (st_tag),
        .st_be       (st_be),
        .st_data     (st_data),
        .st_hit      (st_hit),
        .fill_en     (fill_en),
        .fill_idx    (fill_idx),
        .fill_tag    (fill_tag),
        .fill_data   (fill_data),
        .evict_valid (evict_valid),
        .evict_idx   (evict_idx),
        .evict_tag   (evict_tag),
        .evict_data  (evict_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        rd;
        logic [7:0]  rtag;
        logic        st;
        logic [7:0]  be;
        logic [63:0] sdat;
        logic        fl;
        logic [7:0]  ftag;
        logic [63:0] fdat;
        logic        xhit;
        logic [63:0] xdat;
        logic        xst;
        logic        xev;
        logic [7:0]  xetag;
        logic [63:0] xedat;
    } vec_t;

    typedef struct {
        logic        v;
        logic [3:0]  idx;
        logic [7:0]  tag;
        logic [63:0] data;
    } ev_t;

    localparam int NV = 21;
    localparam logic [63:0] Z  = 64'h0;
    localparam logic [63:0] D1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] DS = 64'hAAAA_AAAA_BBBB_BBBB;
    localparam logic [63:0] DB = 64'h1111_1111_BBBB_BBBB;
    localparam logic [63:0] D3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] D5 = 64'h5656_5656_5656_5656;
    localparam logic [63:0] S9 = 64'h9900_0000_0000_0000;
    localparam logic [63:0] D9 = 64'h9956_5656_5656_5656;
    localparam logic [63:0] D7 = 64'h7878_7878_7878_7878;
    localparam logic [63:0] DF = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] DX = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam logic [63:0] DA = 64'hABAB_ABAB_ABAB_ABAB;
    localparam logic [63:0] DC = 64'hCAFE_F00D_CAFE_F00D;

    vec_t vecs [NV];
    ev_t  sb [$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        reset     = 1'b0;
        rd_en     = '0;
        rd_idx    = '0;
        rd_tag    = '0;
        st_en     = '0;
        st_idx    = '0;
        st_tag    = '0;
        st_be     = '0;
        st_data   = '0;
        fill_en   = 1'b0;
        fill_idx  = '0;
        fill_tag  = '0;
        fill_data = '0;
    endtask

    task automatic tick(input string nm, input ev_t e);
        ev_t x;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            x = sb.pop_front();
            chk({nm, "_ev_valid"}, 64'(evict_valid), 64'(x.v));
            if (x.v) begin
                chk({nm, "_ev_idx"}, 64'(evict_idx), 64'(x.idx));
                chk({nm, "_ev_tag"}, 64'(evict_tag), 64'(x.tag));
                chk({nm, "_ev_data"}, evict_data, x.data);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 8'h12, 1'b0, 8'h00, Z,  1'b0, 8'h00, Z,  1'b0, Z,  1'b0, 1'b0, 8'h00, Z};
        vecs[1]  = '{1'b0, 1'b1, 8'h12, 1'b0, 8'h00, Z,  1'b0, 8'h00, Z,  1'b0, Z,  1'b0, 1'b0, 8'h00, Z};
        vecs[2]  = '{1'b0, 1'b1, 8'h12, 1'b0, 8'h00, Z,  1'b1, 8'h12, D1, 1'b0, Z,  1'b0, 1'b0, 8'h00, Z};
        vecs[3]  = '{1'b0, 1'b1, 8'h12, 1'b0, 8'h00, Z,  1'b0, 8'h00, Z,  1'b1, D1, 1'b0, 1'b0, 8'h00, Z};
        vecs[4]  = '{1'b0, 1'b1, 8'h12, 1'b1, 8'h0F, DS, 1'b0, 8'h00, Z,  1'b1, D1, 1'b1, 1'b0, 8'h00, Z};
        vecs[5]  = '{1'b0, 1'b1, 8'h12, 1'b0, 8'h00, Z,  1'b0, 8'h00, Z,  1'b1, DB, 1'b0, 1'b0, 8'h00, Z};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, Z,  1'b1, 8'h34, D3, 1'b0, Z,  1'b0, 1'b0, 8'h00, Z};
        vecs[7]  = '{1'b0, 1'b1, 8'h34, 1'b0, 8'h00, Z,  1'b0, 8'h00, Z,  1'b1, D3, 1'b0, 1'b0, 8'h00, Z};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, Z,  1'b1, 8'h56, D5, 1'b0, Z,  1'b0, 1'b1, 8'h12, DB};
        vecs[9]  = '{1'b0, 1'b1, 8'h56, 1'b0, 8'h00, Z,  1'b0, 8'h00, Z,  1'b1, D5, 1'b0, 1'b0, 8'h00, Z};
        vecs[10] = '{1'b0, 1'b1, 8'h56, 1'b1, 8'h80, S9, 1'b0, 8'h00, Z,  1'b1, D5, 1'b1, 1'b0, 8'h00, Z};
        vecs[11] = '{1'b0, 1'b1, 8'h34, 1'b0, 8'h00, Z,  1'b0, 8'h00, Z,  1'b1, D3, 1'b0, 1'b0, 8'h00, Z};
        vecs[12] = '{1'b0, 1'b1, 8'h56, 1'b0, 8'h00, Z,  1'b0, 8'h00, Z,  1'b1, D9, 1'b0, 1'b0, 8'h00, Z};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, Z,  1'b1, 8'h78, D7, 1'b0, Z,  1'b0, 1'b0, 8'h00, Z};
        vecs[14] = '{1'b0, 1'b1, 8'h34, 1'b1, 8'hFF, DF, 1'b0, 8'h00, Z,  1'b0, Z,  1'b0, 1'b0, 8'h00, Z};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, Z,  1'b1, 8'h56, DX, 1'b0, Z,  1'b0, 1'b0, 8'h00, Z};
        vecs[16] = '{1'b0, 1'b1, 8'h56, 1'b0, 8'h00, Z,  1'b0, 8'h00, Z,  1'b1, D9, 1'b0, 1'b0, 8'h00, Z};
        vecs[17] = '{1'b0, 1'b1, 8'h78, 1'b0, 8'h00, Z,  1'b0, 8'h00, Z,  1'b1, D7, 1'b0, 1'b0, 8'h00, Z};
        vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, Z,  1'b1, 8'hAB, DA, 1'b0, Z,  1'b0, 1'b1, 8'h56, D9};
        vecs[19] = '{1'b1, 1'b1, 8'h78, 1'b0, 8'h00, Z,  1'b1, 8'hCD, DA, 1'b0, Z,  1'b0, 1'b0, 8'h00, Z};
        vecs[20] = '{1'b0, 1'b1, 8'h78, 1'b0, 8'h00, Z,  1'b0, 8'h00, Z,  1'b0, Z,  1'b0, 1'b0, 8'h00, Z};

        for (int i = 0; i < NV; i++) begin
            idle();
            reset      = vecs[i].rst;
            rd_en[0]   = vecs[i].rd;
            rd_idx[0]  = 4'd3;
            rd_tag[0]  = vecs[i].rtag;
            st_en[0]   = vecs[i].st;
            st_idx[0]  = 4'd3;
            st_tag[0]  = vecs[i].rtag;
            st_be[0]   = vecs[i].be;
            st_data[0] = vecs[i].sdat;
            fill_en    = vecs[i].fl;
            fill_idx   = 4'd3;
            fill_tag   = vecs[i].ftag;
            fill_data  = vecs[i].fdat;
            #1;
            chk($sformatf("r%0d_rd_hit", i), 64'(rd_hit[0]), 64'(vecs[i].xhit));
            chk($sformatf("r%0d_rd_data", i), rd_data[0], vecs[i].xdat);
            chk($sformatf("r%0d_st_hit", i), 64'(st_hit[0]), 64'(vecs[i].xst));
            tick($sformatf("r%0d", i),
                 '{vecs[i].xev, 4'd3, vecs[i].xetag, vecs[i].xedat});
        end

        idle();
        fill_en   = 1'b1;
        fill_idx  = 4'd5;
        fill_tag  = 8'h21;
        fill_data = Z;
        tick("h_fill21", '{1'b0, 4'd0, 8'h00, Z});

        idle();
        st_en      = 2'b11;
        st_idx[0]  = 4'd5;
        st_idx[1]  = 4'd5;
        st_tag[0]  = 8'h21;
        st_tag[1]  = 8'h21;
        st_be[0]   = 8'h03;
        st_be[1]   = 8'h01;
        st_data[0] = 64'h0000_0000_0000_AAAA;
        st_data[1] = 64'h0000_0000_0000_0055;
        #1;
        chk("h_st_hit_both", 64'(st_hit), 64'(2'b11));
        tick("h_st2", '{1'b0, 4'd0, 8'h00, Z});

        idle();
        rd_en      = 3'b110;
        rd_idx[1]  = 4'd5;
        rd_tag[1]  = 8'h21;
        rd_idx[2]  = 4'd5;
        rd_tag[2]  = 8'h22;
        fill_en    = 1'b1;
        fill_idx   = 4'd5;
        fill_tag   = 8'h22;
        fill_data  = 64'h2222_2222_2222_2222;
        #1;
        chk("h_rd_hit_vec", 64'(rd_hit), 64'(3'b010));
        chk("h_merge_data", rd_data[1], 64'h0000_0000_0000_AA55);
        chk("h_miss_data", rd_data[2], Z);
        tick("h_fill22", '{1'b0, 4'd0, 8'h00, Z});

        idle();
        st_en      = 2'b10;
        st_idx[1]  = 4'd5;
        st_tag[1]  = 8'h22;
        st_be[1]   = 8'hFF;
        st_data[1] = DC;
        #1;
        chk("h_st22_hit", 64'(st_hit), 64'(2'b10));
        tick("h_st22", '{1'b0, 4'd0, 8'h00, Z});

        idle();
        fill_en  = 1'b1;
        fill_idx = 4'd5;
        fill_tag = 8'h23;
        tick("h_fill23", '{1'b1, 4'd5, 8'h21, 64'h0000_0000_0000_AA55});

        idle();
        fill_en  = 1'b1;
        fill_idx = 4'd5;
        fill_tag = 8'h24;
        tick("h_fill24", '{1'b1, 4'd5, 8'h22, DC});

        idle();
        rd_en[0]  = 1'b1;
        rd_idx[0] = 4'd5;
        rd_tag[0] = 8'h24;
        #1;
        chk("h_rd24_hit", 64'(rd_hit[0]), 64'd1);
        tick("h_idle", '{1'b0, 4'd0, 8'h00, Z});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
